cnn_infer_ctrl: RTL

//  Frame-level controller and classifier head for the quantised CNN inference pipeline.

---
 rtl/cnn_infer_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/cnn_infer_ctrl.sv
// Frame controller and argmax classifier head for the CNN inference pipeline.
// Optional DRAIN watchdog (adds err_timeout port) enabled by defining CLS_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | waiting for weight loader done
//   ACCEPT | admitting pixels of one frame into the conv chain
//   DRAIN  | frame admitted, folding logit beats into the running argmax
//   RESULT | class result presented, waiting for consumer handshake
module cnn_infer_ctrl #(
   parameter int N         = 8,
   parameter int IN_CH     = 1,
   parameter int IMG_SIZE  = 28,
   parameter int NUM_CLASS = 10,
   parameter int TIMEOUT   = 4096
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         weight_load_done,
   input  logic                         in_vld,
   input  logic [IN_CH*N-1:0]           in_din,
   output logic                         in_rdy,
   output logic                         pix_vld,
   output logic [IN_CH*N-1:0]           pix_din,
   input  logic [NUM_CLASS*N-1:0]       net_dout,
   input  logic                         net_dout_vld,
   input  logic                         net_dout_end,
   output logic                         cls_vld,
   input  logic                         cls_rdy,
   output logic [$clog2(NUM_CLASS)-1:0] cls_idx,
   output logic [N-1:0]                 cls_score,
   output logic [15:0]                  frame_cnt,
   output logic                         busy,
`ifdef CLS_TIMEOUT_EN
   output logic                         err_timeout,
`endif
   output logic                         err_overrun
);

   localparam int IDX_W     = $clog2(NUM_CLASS);
   localparam int PIX_TOTAL = IMG_SIZE * IMG_SIZE;
   localparam int PIX_W     = $clog2(PIX_TOTAL);
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_TOTAL - 1);
   localparam logic [N-1:0]     MAX_NEG  = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCEPT, DRAIN, RESULT} state_t;

   state_t            state;
   logic [PIX_W-1:0]  pix_left;
   logic signed [N-1:0] run_max;
   logic [IDX_W-1:0]  run_idx;
   logic signed [N-1:0] beat_max;
   logic signed [N-1:0] logit;
   logic [IDX_W-1:0]  beat_idx;
   logic              beat_wins;
   logic              accept;

`ifdef CLS_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);
   logic [TMO_W-1:0]  tmo_left;
`endif

   assign in_rdy = (state == ACCEPT);
   assign busy   = (state != IDLE);
   assign accept = in_vld & in_rdy;

   // Strict greater-than keeps the lowest channel on ties within a beat
   always_comb begin
      beat_max = net_dout[N-1:0];
      beat_idx = '0;
      logit    = '0;
      for (int k = 1; k < NUM_CLASS; k++) begin
         logit = net_dout[k*N +: N];
         if (logit > beat_max) begin
            beat_max = logit;
            beat_idx = IDX_W'(k);
         end
      end
   end

   assign beat_wins = (beat_max > run_max);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pix_left    <= '0;
         pix_vld     <= 1'b0;
         pix_din     <= '0;
         run_max     <= MAX_NEG;
         run_idx     <= '0;
         cls_vld     <= 1'b0;
         cls_idx     <= '0;
         cls_score   <= '0;
         frame_cnt   <= '0;
         err_overrun <= 1'b0;
`ifdef CLS_TIMEOUT_EN
         tmo_left    <= '0;
         err_timeout <= 1'b0;
`endif
      end else begin
         pix_vld <= accept;
         if (accept)
            pix_din <= in_din;
         if (net_dout_vld && state != DRAIN)
            err_overrun <= 1'b1;
`ifdef CLS_TIMEOUT_EN
         err_timeout <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (weight_load_done) begin
                  state    <= ACCEPT;
                  pix_left <= PIX_LAST;
               end
            end
            ACCEPT: begin
               if (accept) begin
                  if (pix_left == '0) begin
                     state   <= DRAIN;
                     run_max <= MAX_NEG;
                     run_idx <= '0;
`ifdef CLS_TIMEOUT_EN
                     tmo_left <= TMO_LOAD;
`endif
                  end else begin
                     pix_left <= pix_left - PIX_W'(1);
                  end
               end
            end
            DRAIN: begin
               if (net_dout_vld) begin
                  // Earlier beat keeps the running max on a tie
                  if (beat_wins) begin
                     run_max <= beat_max;
                     run_idx <= beat_idx;
                  end
`ifdef CLS_TIMEOUT_EN
                  tmo_left <= TMO_LOAD;
`endif
                  if (net_dout_end) begin
                     state     <= RESULT;
                     cls_vld   <= 1'b1;
                     cls_idx   <= beat_wins ? beat_idx : run_idx;
                     cls_score <= beat_wins ? beat_max : run_max;
                  end
               end
`ifdef CLS_TIMEOUT_EN
               else if (tmo_left == '0) begin
                  state       <= RESULT;
                  cls_vld     <= 1'b1;
                  cls_idx     <= '1;
                  cls_score   <= '0;
                  err_timeout <= 1'b1;
               end else begin
                  tmo_left <= tmo_left - TMO_W'(1);
               end
`endif
            end
            RESULT: begin
               if (cls_vld && cls_rdy) begin
                  cls_vld   <= 1'b0;
                  frame_cnt <= frame_cnt + 16'd1;
                  state     <= ACCEPT;
                  pix_left  <= PIX_LAST;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
